uniform_rnd_bank: RTL and testbench
===================================

UNIFORM_RND_BANK -- requirements
Module: uniform_rnd_bank

Interface
REQ-001 Parameter WARMUP_CYCLES, default 32, number of discarded generator steps after seeding.
REQ-002 Parameter DEFAULT_SEED, default 32'hACE1_5A30, base seed used at reset and for zero-seed substitution.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 SEED_LOAD  input  1  one-cycle pulse; starts a seed-loading sequence.
REQ-006 SEED_DATA  input  32  seed word for the generator currently indexed.
REQ-007 SEED_VALID  input  1  SEED_DATA valid.
REQ-008 SEED_READY  output  1  block accepts a seed word this cycle.
REQ-009 GEN_EN  input  1  advance generators this cycle (driven by the noise summer's busy window).
REQ-010 RND_VALID  output  1  RND1..RND12 hold a fresh sample produced by the previous cycle's step.
REQ-011 RND1..RND12  output  12 each  uniform samples, unsigned 0..4095, one per generator; feed noise_sum RND1..RND12.

Function
REQ-012 The block SHALL contain 12 independent 32-bit Galois LFSRs, index k = 1..12, right-shifting, feedback mask 32'h8020_0003: when lsb = 1, next = (s >> 1) ^ mask; otherwise next = s >> 1.
REQ-013 One "step" SHALL apply 12 consecutive LFSR shifts combinationally within a single clock, so each sample uses 12 fresh bits.
REQ-014 RNDk SHALL be a register loaded with bits [11:0] of LFSR k's post-step state on every RUN-state step.
REQ-015 The FSM SHALL have states IDLE, LOAD, WARMUP, and RUN.
REQ-016 SEED_LOAD in any state SHALL force LOAD on the next edge: word index cleared to 1, RND_VALID = 0, RNDk held.
REQ-017 In LOAD, SEED_READY SHALL be 1; each cycle with SEED_VALID & SEED_READY SHALL write SEED_DATA into LFSR[index] and increment the index.
REQ-018 A seed word of 0 SHALL be replaced by {DEFAULT_SEED[31:4], k[3:0]}, because the all-zero state is a lock-up state.
REQ-019 Acceptance of word 12 SHALL move the FSM to WARMUP with the warm-up counter = WARMUP_CYCLES; SEED_READY = 0 outside LOAD.
REQ-020 In WARMUP, each GEN_EN cycle SHALL step all LFSRs and decrement the counter without updating RNDk; counter = 0 (including WARMUP_CYCLES = 0) SHALL move to RUN with no step taken that cycle.
REQ-021 In RUN, GEN_EN = 1 SHALL step all LFSRs and update RNDk, and RND_VALID SHALL be 1 on the following cycle (1-cycle latency).
REQ-022 In RUN, GEN_EN = 0 SHALL hold the LFSRs and RNDk, and RND_VALID SHALL be 0.
REQ-023 In IDLE, GEN_EN SHALL be ignored; IDLE is left only via SEED_LOAD.
REQ-024 When SEED_LOAD and GEN_EN are high together, SEED_LOAD SHALL win and no step is taken.
REQ-025 When SEED_LOAD arrives mid-LOAD, the sequence SHALL restart at index 1; already written LFSRs keep their values until overwritten.

Reset
REQ-026 While RESET = 1: state = WARMUP, counter = WARMUP_CYCLES, LFSR k = {DEFAULT_SEED[31:4], k[3:0]}, RNDk = 0, RND_VALID = 0, SEED_READY = 0.
REQ-027 Reset assertion mid-LOAD, mid-WARMUP, or mid-RUN SHALL take effect immediately and abort the sequence, with no partial-seed retention.

Verification
REQ-028 Assert RESET, then release with GEN_EN = 0 -> all RNDk = 0, RND_VALID = 0, SEED_READY = 0, state WARMUP.
REQ-029 WARMUP_CYCLES = 0; load seeds 1..12 (SEED_VALID held); pulse GEN_EN once -> SEED_READY high for exactly 12 cycles; next cycle RND1 = 12'hC01 with RND_VALID = 1 for one cycle.
REQ-030 Default parameters; load 12 seeds, hold GEN_EN = 1 -> RND_VALID first rises on cycle 34 after the last seed acceptance (32 warm-up steps, one transition cycle, one step cycle), then stays 1.
REQ-031 Load seed word 0 for k = 5 -> LFSR5 = {DEFAULT_SEED[31:4], 4'h5}; RND5 is never stuck at 0 over 1000 steps.
REQ-032 In RUN, toggle GEN_EN 1,0,1 -> RNDk held and RND_VALID = 0 during the 0 cycle; the sequence continues with no skipped step (compare against a reference model).
REQ-033 SEED_LOAD pulsed after 6 accepted words, and RESET asserted during RUN -> index restarts at 1 / outputs clear asynchronously, with values matching REQ-026.

Source files
------------

// File: rtl/uniform_rnd_bank.sv
// Bank of twelve 32-bit Galois LFSRs producing 12-bit uniform samples for the noise summer.
// Seeds are loaded word by word, the generators are warmed up, then sampled on each GEN_EN step.
module uniform_rnd_bank #(
    parameter int unsigned WARMUP_CYCLES = 32,
    parameter logic [31:0] DEFAULT_SEED  = 32'hACE1_5A30
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SEED_LOAD,
    input  logic [31:0] SEED_DATA,
    input  logic        SEED_VALID,
    output logic        SEED_READY,
    input  logic        GEN_EN,
    output logic        RND_VALID,
    output logic [11:0] RND1,
    output logic [11:0] RND2,
    output logic [11:0] RND3,
    output logic [11:0] RND4,
    output logic [11:0] RND5,
    output logic [11:0] RND6,
    output logic [11:0] RND7,
    output logic [11:0] RND8,
    output logic [11:0] RND9,
    output logic [11:0] RND10,
    output logic [11:0] RND11,
    output logic [11:0] RND12
);

    localparam int unsigned NUM_GEN   = 12;
    localparam int unsigned STEP_BITS = 12;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StWarmup = 2'd2,
        StRun    = 2'd3
    } state_e;

    // Twelve Galois shifts per step so every sample is built from fresh bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < STEP_BITS; i++) begin
            v = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
        end
        return v;
    endfunction

    // Per-generator substitute seed; never zero, so the LFSR cannot lock up.
    function automatic logic [31:0] seed_fill(input logic [3:0] k);
        return {DEFAULT_SEED[31:4], k};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;

    logic        do_step;
    logic        rnd_upd;
    logic        write_seed;
    logic [31:0] seed_word;

    logic [31:0] lfsr_q   [NUM_GEN];
    logic [31:0] lfsr_nxt [NUM_GEN];
    logic [11:0] rnd_q    [NUM_GEN];

    always_comb begin
        for (int k = 0; k < NUM_GEN; k++) begin
            lfsr_nxt[k] = lfsr_step(lfsr_q[k]);
        end
    end

    assign seed_word = (SEED_DATA == '0) ? seed_fill(idx_q) : SEED_DATA;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        do_step    = 1'b0;
        rnd_upd    = 1'b0;
        write_seed = 1'b0;
        SEED_READY = 1'b0;

        // SEED_LOAD overrides everything, including a concurrent GEN_EN.
        if (SEED_LOAD) begin
            state_d = StLoad;
            idx_d   = 4'd1;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StLoad: begin
                    SEED_READY = 1'b1;
                    if (SEED_VALID) begin
                        write_seed = 1'b1;
                        if (idx_q == 4'(NUM_GEN)) begin
                            state_d = StWarmup;
                            idx_d   = 4'd1;
                            cnt_d   = WARMUP_CYCLES;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                StWarmup: begin
                    // The exhausted-counter cycle is spent on the transition alone.
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else if (GEN_EN) begin
                        do_step = 1'b1;
                        cnt_d   = cnt_q - 32'd1;
                    end
                end
                StRun: begin
                    if (GEN_EN) begin
                        do_step = 1'b1;
                        rnd_upd = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StWarmup;
            idx_q   <= 4'd1;
            cnt_q   <= WARMUP_CYCLES;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < NUM_GEN; k++) begin
                lfsr_q[k] <= seed_fill(4'(k + 1));
                rnd_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_GEN; k++) begin
                if (write_seed && (idx_q == 4'(k + 1))) begin
                    lfsr_q[k] <= seed_word;
                end else if (do_step) begin
                    lfsr_q[k] <= lfsr_nxt[k];
                end
                if (rnd_upd) begin
                    rnd_q[k] <= lfsr_nxt[k][11:0];
                end
            end
        end
    end

    assign RND_VALID = valid_q;
    assign RND1      = rnd_q[0];
    assign RND2      = rnd_q[1];
    assign RND3      = rnd_q[2];
    assign RND4      = rnd_q[3];
    assign RND5      = rnd_q[4];
    assign RND6      = rnd_q[5];
    assign RND7      = rnd_q[6];
    assign RND8      = rnd_q[7];
    assign RND9      = rnd_q[8];
    assign RND10     = rnd_q[9];
    assign RND11     = rnd_q[10];
    assign RND12     = rnd_q[11];

endmodule

// File: tb/tb_uniform_rnd_bank.sv
// Scoreboard bench for uniform_rnd_bank: the stimulus process predicts samples from an
// arithmetic LFSR model, a negedge monitor pops and compares whenever RND_VALID is seen.
module tb_uniform_rnd_bank;

    localparam logic [31:0] DSEED = 32'hACE1_5A30;
    localparam logic [31:0] MASK  = 32'h8020_0003;
    localparam int          WARM  = 32;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        seed_load, seed_valid, seed_ready, gen_en, rnd_valid;
    logic [31:0] seed_data;
    logic [11:0] rnd [12];

    logic        s0_load, s0_valid, s0_ready, s0_gen, s0_rvalid;
    logic [31:0] s0_data;
    logic [11:0] r0 [12];

    always #5 CLK = ~CLK;

    uniform_rnd_bank dut (
        .CLK(CLK), .RESET(RESET), .SEED_LOAD(seed_load), .SEED_DATA(seed_data),
        .SEED_VALID(seed_valid), .SEED_READY(seed_ready), .GEN_EN(gen_en),
        .RND_VALID(rnd_valid),
        .RND1(rnd[0]), .RND2(rnd[1]), .RND3(rnd[2]), .RND4(rnd[3]), .RND5(rnd[4]),
        .RND6(rnd[5]), .RND7(rnd[6]), .RND8(rnd[7]), .RND9(rnd[8]), .RND10(rnd[9]),
        .RND11(rnd[10]), .RND12(rnd[11])
    );

    uniform_rnd_bank #(.WARMUP_CYCLES(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .SEED_LOAD(s0_load), .SEED_DATA(s0_data),
        .SEED_VALID(s0_valid), .SEED_READY(s0_ready), .GEN_EN(s0_gen),
        .RND_VALID(s0_rvalid),
        .RND1(r0[0]), .RND2(r0[1]), .RND3(r0[2]), .RND4(r0[3]), .RND5(r0[4]),
        .RND6(r0[5]), .RND7(r0[6]), .RND8(r0[7]), .RND9(r0[8]), .RND10(r0[9]),
        .RND11(r0[10]), .RND12(r0[11])
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   m     [12];
    logic [31:0]   seeds [12];
    logic [143:0]  exp_q [$];
    logic [143:0]  last_rnd = '0;
    bit            cnt0_en = 1'b0;
    int            ready0_cnt = 0;

    // Reference generator: twelve shifts of s, using division instead of bit selects.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        repeat (12) begin
            if (v % 2 == 1) v = (v / 2) ^ MASK;
            else            v = v / 2;
        end
        return v;
    endfunction

    function automatic logic [143:0] pack_main();
        logic [143:0] p;
        for (int k = 0; k < 12; k++) p[k*12 +: 12] = rnd[k];
        return p;
    endfunction

    function automatic logic [143:0] pack_model();
        logic [143:0] p;
        for (int k = 0; k < 12; k++) p[k*12 +: 12] = m[k][11:0];
        return p;
    endfunction

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            check("reset_rnd", pack_main(), '0);
            check("reset_flags", {142'b0, rnd_valid, seed_ready}, '0);
            last_rnd = '0;
        end else if (rnd_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got RND_VALID=1 expected 0 at %0t", $time);
            end else begin
                logic [143:0] e;
                e = exp_q.pop_front();
                check("sample", pack_main(), e);
                last_rnd = e;
            end
        end else begin
            check("hold", pack_main(), last_rnd);
        end
    end

    always @(negedge CLK) if (cnt0_en && s0_ready) ready0_cnt++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 12; k++) m[k] = {DSEED[31:4], 4'(k + 1)};
    endtask

    task automatic model_step_all();
        for (int k = 0; k < 12; k++) m[k] = ref_step(m[k]);
    endtask

    task automatic warmup_random(input int w);
        int left;
        left = w;
        while (left > 0) begin
            gen_en = 1'($urandom % 2);
            tick();
            if (gen_en) begin
                model_step_all();
                left--;
            end
        end
        gen_en = 1'($urandom % 2);  // transition cycle: never steps
        tick();
        gen_en = 1'b0;
    endtask

    task automatic run_steps(input int n, input int pct);
        int done;
        int cyc;
        done = 0;
        cyc  = 0;
        while (done < n && cyc < n * 50) begin
            gen_en = (int'($urandom % 100) < pct);
            tick();
            cyc++;
            if (gen_en) begin
                model_step_all();
                exp_q.push_back(pack_model());
                done++;
            end
        end
        gen_en = 1'b0;
    endtask

    task automatic load_seeds(input int nwords);
        seed_load  = 1'b1;
        seed_valid = 1'b1;
        seed_data  = $urandom;
        @(negedge CLK);
        check("ready_on_load_pulse", {143'b0, seed_ready}, 144'd0);
        tick();
        seed_load = 1'b0;
        gen_en    = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            repeat ($urandom % 3) begin
                seed_valid = 1'b0;
                tick();
            end
            seed_valid = 1'b1;
            seed_data  = seeds[i];
            @(negedge CLK);
            check("seed_ready", {143'b0, seed_ready}, 144'd1);
            tick();
            m[i] = (seeds[i] == 32'd0) ? {DSEED[31:4], 4'(i + 1)} : seeds[i];
        end
        seed_valid = 1'b0;
    endtask

    task automatic dut0_test();
        logic [143:0] e;
        logic [31:0]  v;
        cnt0_en = 1'b1;
        s0_load = 1'b1;
        tick();
        s0_load  = 1'b0;
        s0_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s0_data = 32'(i + 1);
            tick();
        end
        s0_valid = 1'b0;
        tick();  // WARMUP with zero count -> RUN
        s0_gen = 1'b1;
        tick();
        s0_gen = 1'b0;
        @(negedge CLK);
        check("w0_rnd1", {132'b0, r0[0]}, {132'b0, 12'hC01});
        check("w0_valid", {143'b0, s0_rvalid}, 144'd1);
        for (int k = 0; k < 12; k++) begin
            v = ref_step(32'(k + 1));
            e[k*12 +: 12] = v[11:0];
        end
        begin
            logic [143:0] p;
            for (int k = 0; k < 12; k++) p[k*12 +: 12] = r0[k];
            check("w0_all", p, e);
        end
        tick();
        @(negedge CLK);
        check("w0_valid_drop", {143'b0, s0_rvalid}, 144'd0);
        check("w0_rnd1_held", {132'b0, r0[0]}, {132'b0, 12'hC01});
        tick();
        cnt0_en = 1'b0;
        check("w0_ready_cycles", 144'(ready0_cnt), 144'd12);
    endtask

    initial begin
        int zeros;
        RESET      = 1'b1;
        seed_load  = 1'b0;
        seed_valid = 1'b0;
        seed_data  = '0;
        gen_en     = 1'b0;
        s0_load    = 1'b0;
        s0_valid   = 1'b0;
        s0_data    = '0;
        s0_gen     = 1'b0;
        m_reset();
        repeat (3) tick();
        RESET = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("post_reset_flags", {142'b0, rnd_valid, seed_ready}, '0);
            tick();
        end

        dut0_test();

        // Free-run from the reset seeds, then a directed 1,0,1 enable pattern.
        warmup_random(WARM);
        run_steps(150, 50);
        run_steps(1, 100);
        gen_en = 1'b0;
        tick();
        run_steps(1, 100);

        // Fresh seeds with word 5 zero; GEN_EN held through warm-up.
        for (int i = 0; i < 12; i++) seeds[i] = $urandom | 32'h1;
        seeds[4] = 32'd0;
        gen_en = 1'b1;  // coincides with the SEED_LOAD pulse, which must win
        load_seeds(12);
        gen_en = 1'b1;
        zeros  = 0;
        for (int i = 0; i < WARM + 1; i++) begin
            tick();
            if (i < WARM) model_step_all();
            @(negedge CLK);
            if (!rnd_valid) zeros++;
        end
        check("valid_low_cycles", 144'(zeros), 144'(WARM + 1));
        for (int i = 0; i < 20; i++) begin
            tick();
            model_step_all();
            exp_q.push_back(pack_model());
            @(negedge CLK);
            check("valid_held_high", {143'b0, rnd_valid}, 144'd1);
        end
        run_steps(1000, 75);

        // Restart mid-load after six words.
        for (int i = 0; i < 12; i++) seeds[i] = $urandom;
        load_seeds(6);
        for (int i = 0; i < 12; i++) seeds[i] = $urandom;
        load_seeds(12);
        warmup_random(WARM);
        run_steps(100, 60);

        // Asynchronous reset in RUN, right after a step.
        run_steps(1, 100);
        RESET = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_rnd", pack_main(), '0);
        check("async_reset_flags", {142'b0, rnd_valid, seed_ready}, '0);
        m_reset();
        repeat (2) tick();
        RESET = 1'b0;
        warmup_random(WARM);
        run_steps(100, 50);

        repeat (2) tick();
        check("queue_drained", 144'(exp_q.size()), 144'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
